// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
//   Groups the soft-reset handshake and the sequencer status outputs.
//   master : the agent that requests a soft reset and observes the domains
//   slave  : the reset_sequencer itself
//   sw_rst_req  level request for a soft reset (master -> slave)
//   sw_rst_ack  one-cycle acceptance pulse     (slave -> master)
//   rst_out_n   per-domain active-low resets, index 0 released first
//   seq_done    every domain released
//   busy        sequencer not in its idle/done state
//   cur_stage   number of domains currently released
`timescale 1ns/1ps
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    localparam int STG_W = $clog2(NUM_STAGES + 1);

    logic                  sw_rst_req;
    logic                  sw_rst_ack;
    logic [NUM_STAGES-1:0] rst_out_n;
    logic                  seq_done;
    logic                  busy;
    logic [STG_W-1:0]      cur_stage;

    modport master (
        output sw_rst_req,
        input  sw_rst_ack,
        input  rst_out_n,
        input  seq_done,
        input  busy,
        input  cur_stage
    );

    modport slave (
        input  sw_rst_req,
        output sw_rst_ack,
        output rst_out_n,
        output seq_done,
        output busy,
        output cur_stage
    );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Synchronises deassertion of the board reset, then releases NUM_STAGES
//   ordered reset domains, one every STAGE_DLY cycles. A soft-reset request
//   accepted while DONE re-asserts every domain for SW_RST_HOLD cycles and
//   re-runs the release sequence without the synchroniser wait.
//   clk    : clock, all state on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : reset_sequencer_if.slave (request/ack handshake and status)
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   S_SYNC    | waiting for the deassert synchroniser to fill
//   S_RELEASE | releasing one domain every STAGE_DLY cycles
//   S_DONE    | all domains released, soft-reset request accepted here
//   S_SW_HOLD | soft reset accepted, every domain held for SW_RST_HOLD
`timescale 1ns/1ps
module reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int STAGE_DLY   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int SW_RST_HOLD = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    reset_sequencer_if.slave    bus
);
    localparam int CNT_MAX = (STAGE_DLY > SW_RST_HOLD) ? STAGE_DLY : SW_RST_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int STG_W   = $clog2(NUM_STAGES + 1);

    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SW_RST_HOLD - 1);
    localparam logic [STG_W-1:0] STG_LAST   = STG_W'(NUM_STAGES - 1);

    if (NUM_STAGES < 1) begin : g_bad_num_stages
        $fatal(1, "reset_sequencer: NUM_STAGES must be >= 1");
    end
    if (STAGE_DLY < 1) begin : g_bad_stage_dly
        $fatal(1, "reset_sequencer: STAGE_DLY must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $fatal(1, "reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (SW_RST_HOLD < 1) begin : g_bad_sw_rst_hold
        $fatal(1, "reset_sequencer: SW_RST_HOLD must be >= 1");
    end

    typedef enum logic [1:0] {
        S_SYNC    = 2'd0,
        S_RELEASE = 2'd1,
        S_DONE    = 2'd2,
        S_SW_HOLD = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
    logic [STG_W-1:0]      stage_q, stage_d;
    logic                  seq_done_q, seq_done_d;
    logic                  busy_q, busy_d;
    logic                  ack_q, ack_d;
    logic                  sync_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // High when rst_sync (last chain flop) is 1 after this edge. RELEASE is
    // entered on the edge rst_sync rises, so stage k lands exactly at edge
    // SYNC_STAGES + (k+1)*STAGE_DLY.
    assign sync_ready = sync_q[SYNC_STAGES-1] | sync_q[SYNC_STAGES-2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_SYNC;
            cnt_q      <= '0;
            rst_out_q  <= '0;
            stage_q    <= '0;
            seq_done_q <= 1'b0;
            busy_q     <= 1'b1;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_out_q  <= rst_out_d;
            stage_q    <= stage_d;
            seq_done_q <= seq_done_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rst_out_d  = rst_out_q;
        stage_d    = stage_q;
        seq_done_d = seq_done_q;
        ack_d      = 1'b0;

        case (state_q)
            S_SYNC: begin
                if (sync_ready) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end
            end

            S_RELEASE: begin
                if (cnt_q == STAGE_LAST) begin
                    cnt_d = '0;
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        if (stage_q == STG_W'(i)) begin
                            rst_out_d[i] = 1'b1;
                        end
                    end
                    stage_d = stage_q + 1'b1;
                    if (stage_q == STG_LAST) begin
                        state_d    = S_DONE;
                        seq_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                if (bus.sw_rst_req) begin
                    state_d    = S_SW_HOLD;
                    cnt_d      = '0;
                    rst_out_d  = '0;
                    stage_d    = '0;
                    seq_done_d = 1'b0;
                    ack_d      = 1'b1;
                end
            end

            S_SW_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_SYNC;
            end
        endcase

        busy_d = (state_d != S_DONE);
    end

    assign bus.sw_rst_ack = ack_q;
    assign bus.rst_out_n  = rst_out_q;
    assign bus.seq_done   = seq_done_q;
    assign bus.busy       = busy_q;
    assign bus.cur_stage  = stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Directed vector table for power-on, busy-time request and soft reset,
//   hand-written sequences for the mid-sequence reset and a held request,
//   and a jittered random soak compared against an arithmetic model.
`timescale 1ns/1ps
module tb_reset_sequencer;
    localparam int NUM  = 3;
    localparam int SD   = 16;
    localparam int SS   = 2;
    localparam int HOLD = 8;
    localparam int NV   = 20;

    typedef struct {
        int       edge_no;
        logic     req;
        logic [2:0] exp_rst;
        int       exp_stage;
        logic     exp_done;
        logic     exp_busy;
        logic     exp_ack;
    } vec_t;

    logic clk;
    logic rst_n;
    bit   jitter_en;

    reset_sequencer_if #(.NUM_STAGES(NUM)) bus ();

    reset_sequencer #(
        .NUM_STAGES (NUM),
        .STAGE_DLY  (SD),
        .SYNC_STAGES(SS),
        .SW_RST_HOLD(HOLD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        real p;
        clk = 1'b0;
        forever begin
            p = jitter_en ? (9.5 + $urandom_range(0, 1000) / 1000.0) : 10.0;
            #(p * 0.7) clk = 1'b1;
            #(p * 0.3) clk = 1'b0;
        end
    end

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    bit rst_seen = 0;

    // Model: domains released = floor((e - anchor) / SD), clamped to [0, NUM],
    // where e counts edges since deassertion and anchor is SS at power-on or
    // acceptance edge + HOLD after a soft reset.
    int m_e, m_anchor, m_rel, m_acks;
    bit m_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, edge_n, act, exp);
        end
    endtask

    task automatic model_reset();
        m_e      = 0;
        m_anchor = SS;
        m_rel    = 0;
        m_ack    = 0;
    endtask

    task automatic model_edge(input logic req);
        bit was_done;
        was_done = (m_rel == NUM);
        m_e++;
        m_ack = 0;
        if (was_done && req) begin
            m_ack    = 1;
            m_anchor = m_e + HOLD;
            m_acks++;
        end
        m_rel = (m_e >= m_anchor) ? (m_e - m_anchor) / SD : 0;
        if (m_rel > NUM) m_rel = NUM;
    endtask

    function automatic logic [7:0] model_vec();
        logic [2:0] r;
        r = 3'((1 << m_rel) - 1);
        return {m_ack, (m_rel != NUM), (m_rel == NUM), 2'(m_rel), r};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {bus.sw_rst_ack, bus.busy, bus.seq_done, bus.cur_stage, bus.rst_out_n};
    endfunction

    task automatic check_model(input string name);
        check(name, 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (rst_seen) model_reset();
            model_edge(bus.sw_rst_req);
        end
        rst_seen = 0;
        edge_n++;
    endtask

    task automatic do_por();
        rst_n    = 1'b0;
        rst_seen = 1;
        next_edge();
        #1 rst_n = 1'b1;
        edge_n = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rst_out"}, 32'(bus.rst_out_n), 32'd0);
        check({name, "_done"},    32'(bus.seq_done),  32'd0);
        check({name, "_busy"},    32'(bus.busy),      32'd1);
        check({name, "_stage"},   32'(bus.cur_stage), 32'd0);
        check({name, "_ack"},     32'(bus.sw_rst_ack), 32'd0);
    endtask

    vec_t tbl[NV];
    int   ack_edges[$];
    int   idx;
    int   events;
    int   seen_acks;
    int   r;

    initial begin
        tbl[0]  = '{1,   1'b0, 3'b000, 0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{2,   1'b0, 3'b000, 0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{17,  1'b0, 3'b000, 0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{18,  1'b0, 3'b001, 1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{30,  1'b1, 3'b001, 1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{31,  1'b0, 3'b001, 1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{33,  1'b0, 3'b001, 1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{34,  1'b0, 3'b011, 2, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{49,  1'b0, 3'b011, 2, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{50,  1'b0, 3'b111, 3, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{51,  1'b0, 3'b111, 3, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{52,  1'b1, 3'b000, 0, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{53,  1'b0, 3'b000, 0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{75,  1'b0, 3'b000, 0, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{76,  1'b0, 3'b001, 1, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{91,  1'b0, 3'b001, 1, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{92,  1'b0, 3'b011, 2, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{107, 1'b0, 3'b011, 2, 1'b0, 1'b1, 1'b0};
        tbl[18] = '{108, 1'b0, 3'b111, 3, 1'b1, 1'b0, 1'b0};
        tbl[19] = '{109, 1'b0, 3'b111, 3, 1'b1, 1'b0, 1'b0};

        jitter_en      = 0;
        rst_n          = 1'b0;
        bus.sw_rst_req = 1'b0;
        m_acks         = 0;
        model_reset();

        // Reset state, held across a couple of edges.
        #22;
        check_reset_outputs("por_reset");

        // Power-on, request while busy, soft reset at A=52.
        do_por();
        idx = 0;
        for (int e = 1; e <= 110; e++) begin
            bus.sw_rst_req = (idx < NV && tbl[idx].edge_no == e) ? tbl[idx].req : 1'b0;
            next_edge();
            if (idx < NV && tbl[idx].edge_no == e) begin
                check("tbl_rst_out", 32'(bus.rst_out_n),  32'(tbl[idx].exp_rst));
                check("tbl_stage",   32'(bus.cur_stage),  32'(tbl[idx].exp_stage));
                check("tbl_done",    32'(bus.seq_done),   32'(tbl[idx].exp_done));
                check("tbl_busy",    32'(bus.busy),       32'(tbl[idx].exp_busy));
                check("tbl_ack",     32'(bus.sw_rst_ack), 32'(tbl[idx].exp_ack));
                idx++;
            end
        end
        check("tbl_all_applied", 32'(idx), 32'(NV));
        bus.sw_rst_req = 1'b0;

        // Short rst_n pulse between edges 25 and 26, then full restart.
        do_por();
        repeat (25) next_edge();
        check("midrst_pre", 32'(bus.rst_out_n), 32'b001);
        #1 rst_n = 1'b0;
        rst_seen = 1;
        #1 check_reset_outputs("midrst_async");
        #2 rst_n = 1'b1;
        edge_n = 0;
        repeat (17) next_edge();
        check("midrst_e17", 32'(bus.rst_out_n), 32'b000);
        next_edge();
        check("midrst_e18", 32'(bus.rst_out_n), 32'b001);
        check("midrst_e18_stage", 32'(bus.cur_stage), 32'd1);
        repeat (32) next_edge();
        check("midrst_e50", 32'(bus.rst_out_n), 32'b111);
        check("midrst_e50_done", 32'(bus.seq_done), 32'd1);

        // Request held high from edge 10.
        do_por();
        repeat (9) next_edge();
        bus.sw_rst_req = 1'b1;
        ack_edges.delete();
        for (int e = 10; e <= 120; e++) begin
            next_edge();
            if (bus.sw_rst_ack === 1'b1) ack_edges.push_back(edge_n);
        end
        bus.sw_rst_req = 1'b0;
        check("held_ack_count", 32'(ack_edges.size()), 32'd2);
        check("held_ack_first",  32'(ack_edges.size() > 0 ? ack_edges[0] : 0), 32'd51);
        check("held_ack_second", 32'(ack_edges.size() > 1 ? ack_edges[1] : 0), 32'd108);

        // Jittered soak against the model.
        jitter_en = 1;
        do_por();
        m_acks    = 0;
        seen_acks = 0;
        events    = 0;
        for (int cyc = 0; cyc < 20000 && events < 200; cyc++) begin
            next_edge();
            check_model("soak");
            if (bus.sw_rst_ack === 1'b1) seen_acks++;
            r = $urandom_range(0, 399);
            if (r == 0) begin
                #1 rst_n = 1'b0;
                rst_seen = 1;
                model_reset();
                #1 check_model("soak_short_rst");
                #1 rst_n = 1'b1;
                events++;
            end else if (r == 1) begin
                #1 rst_n = 1'b0;
                rst_seen = 1;
                model_reset();
                #1 check_model("soak_long_rst");
                repeat ($urandom_range(1, 3)) begin
                    next_edge();
                    check_model("soak_in_rst");
                end
                #1 rst_n = 1'b1;
                events++;
            end else if (r < 22) begin
                bus.sw_rst_req = ~bus.sw_rst_req;
                events++;
            end
        end
        check("soak_events", 32'(events >= 200), 32'd1);
        check("soak_ack_total", 32'(seen_acks), 32'(m_acks));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
